cfg_chain_loader: RTL and testbench

Configuration-chain master that drives the serial CRAM chain of a logic-element column. It accepts the bitstream as parallel words over a valid/ready port and shifts it into the chain MSB-first on `config_data_in`/`config_en`. At the same time it captures the displaced old contents from the chain tail (`config_data_out`) and returns them as readback words over a second valid/ready port. It sits between the fabric programming interface and the first LE in the chain.

---
 rtl/cfg_chain_loader.sv | 211 +++++++++++++++++++++
 tb/tb_cfg_chain_loader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cfg_chain_loader.sv
// Configuration-chain master: streams bitstream words MSB-first into a serial CRAM chain
// and returns the displaced chain contents as left-aligned readback words.
module cfg_chain_loader #(
    parameter int CHAIN_LEN = 20,
    parameter int WORD_W    = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [WORD_W-1:0] wdata,
    input  logic              wvalid,
    output logic              wready,
    output logic              config_data_in,
    output logic              config_en,
    input  logic              config_data_out,
    output logic [WORD_W-1:0] rdata,
    output logic              rvalid,
    input  logic              rready,
    output logic              busy,
    output logic              done
);
    localparam int NW        = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int LAST_BITS = (CHAIN_LEN % WORD_W == 0) ? WORD_W : (CHAIN_LEN % WORD_W);
    localparam int BCW       = $clog2(CHAIN_LEN + 1);
    localparam int WCW       = $clog2(NW + 1);
    localparam int SCW       = $clog2(WORD_W + 1);
    localparam int CCW       = $clog2(WORD_W);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN} state_t;

    state_t            state_reg, state_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic [BCW-1:0]    bcnt_reg, bcnt_next;
    logic [WCW-1:0]    wcnt_reg, wcnt_next;
    logic [WORD_W-1:0] buf_reg, buf_next;
    logic              buf_full_reg, buf_full_next;
    logic              buf_last_reg, buf_last_next;
    logic [WORD_W-1:0] sh_reg, sh_next;
    logic [SCW-1:0]    sh_cnt_reg, sh_cnt_next;
    logic [WORD_W-1:0] cap_reg, cap_next;
    logic [CCW-1:0]    cap_cnt_reg, cap_cnt_next;
    logic              cap_full_reg, cap_full_next;
    logic [WORD_W-1:0] rdata_reg, rdata_next;
    logic              rvalid_reg, rvalid_next;
    logic              en_reg, en_next;
    logic              din_reg, din_next;
    logic [WORD_W-1:0] cap_word;
    logic              wready_int, accept_w, rd_free, final_acc;

    assign wready_int = busy_reg && !buf_full_reg && (wcnt_reg < WCW'(NW));
    assign accept_w   = wvalid && wready_int;
    assign rd_free    = !rvalid_reg || rready;
    assign final_acc  = rvalid_reg && rready && !cap_full_reg;

    always_comb begin
        state_next    = state_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        bcnt_next     = bcnt_reg;
        wcnt_next     = wcnt_reg;
        buf_next      = buf_reg;
        buf_full_next = buf_full_reg;
        buf_last_next = buf_last_reg;
        sh_next       = sh_reg;
        sh_cnt_next   = sh_cnt_reg;
        cap_next      = cap_reg;
        cap_cnt_next  = cap_cnt_reg;
        cap_full_next = cap_full_reg;
        rdata_next    = rdata_reg;
        rvalid_next   = rvalid_reg && !rready;
        en_next       = 1'b0;
        din_next      = din_reg;
        cap_word      = cap_reg;

        // A completed capture parked behind an unaccepted rdata moves up once rdata frees.
        if (cap_full_reg && rd_free) begin
            rdata_next    = cap_reg;
            rvalid_next   = 1'b1;
            cap_full_next = 1'b0;
            cap_next      = '0;
        end

        if (en_reg) begin
            cap_word[CCW'(WORD_W - 1) - cap_cnt_reg] = config_data_out;
            bcnt_next = bcnt_reg + 1'b1;
            if (cap_cnt_reg == CCW'(WORD_W - 1) || bcnt_reg == BCW'(CHAIN_LEN - 1)) begin
                cap_cnt_next = '0;
                if (rd_free) begin
                    rdata_next  = cap_word;
                    rvalid_next = 1'b1;
                    cap_next    = '0;
                end else begin
                    cap_next      = cap_word;
                    cap_full_next = 1'b1;
                end
            end else begin
                cap_next     = cap_word;
                cap_cnt_next = cap_cnt_reg + 1'b1;
            end
        end

        // Issue decision is one cycle ahead of the shift, so it looks at the next capture state.
        if (state_reg == ST_LOAD) begin
            if (sh_cnt_reg == '0 && buf_full_reg) begin
                sh_next       = buf_reg;
                sh_cnt_next   = buf_last_reg ? SCW'(LAST_BITS) : SCW'(WORD_W);
                buf_full_next = 1'b0;
            end
            if (sh_cnt_next != '0 && !cap_full_next) begin
                en_next     = 1'b1;
                din_next    = sh_next[WORD_W-1];
                sh_next     = {sh_next[WORD_W-2:0], 1'b0};
                sh_cnt_next = sh_cnt_next - 1'b1;
            end
        end

        if (accept_w) begin
            buf_next      = wdata;
            buf_full_next = 1'b1;
            buf_last_next = (wcnt_reg == WCW'(NW - 1));
            wcnt_next     = wcnt_reg + 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next    = ST_LOAD;
                    busy_next     = 1'b1;
                    bcnt_next     = '0;
                    wcnt_next     = '0;
                    buf_full_next = 1'b0;
                    buf_last_next = 1'b0;
                    sh_cnt_next   = '0;
                    cap_next      = '0;
                    cap_cnt_next  = '0;
                    cap_full_next = 1'b0;
                    rvalid_next   = 1'b0;
                    en_next       = 1'b0;
                end
            end
            ST_LOAD: begin
                if (bcnt_reg == BCW'(CHAIN_LEN)) begin
                    if (final_acc) begin
                        state_next = ST_IDLE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (final_acc) begin
                    state_next = ST_IDLE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg    <= ST_IDLE;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            bcnt_reg     <= '0;
            wcnt_reg     <= '0;
            buf_reg      <= '0;
            buf_full_reg <= 1'b0;
            buf_last_reg <= 1'b0;
            sh_reg       <= '0;
            sh_cnt_reg   <= '0;
            cap_reg      <= '0;
            cap_cnt_reg  <= '0;
            cap_full_reg <= 1'b0;
            rdata_reg    <= '0;
            rvalid_reg   <= 1'b0;
            en_reg       <= 1'b0;
            din_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            bcnt_reg     <= bcnt_next;
            wcnt_reg     <= wcnt_next;
            buf_reg      <= buf_next;
            buf_full_reg <= buf_full_next;
            buf_last_reg <= buf_last_next;
            sh_reg       <= sh_next;
            sh_cnt_reg   <= sh_cnt_next;
            cap_reg      <= cap_next;
            cap_cnt_reg  <= cap_cnt_next;
            cap_full_reg <= cap_full_next;
            rdata_reg    <= rdata_next;
            rvalid_reg   <= rvalid_next;
            en_reg       <= en_next;
            din_reg      <= din_next;
        end
    end

    assign wready         = wready_int;
    assign config_en      = en_reg;
    assign config_data_in = din_reg;
    assign rdata          = rdata_reg;
    assign rvalid         = rvalid_reg;
    assign busy           = busy_reg;
    assign done           = done_reg;
endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench for cfg_chain_loader driving a 20-bit serial chain model.
module tb_cfg_chain_loader;
    localparam int CL = 20;
    localparam int WW = 8;

    logic          clk = 1'b0;
    logic          nrst;
    logic          start;
    logic [WW-1:0] wdata;
    logic          wvalid;
    logic          wready;
    logic          config_data_in;
    logic          config_en;
    logic          config_data_out;
    logic [WW-1:0] rdata;
    logic          rvalid;
    logic          rready;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    cfg_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
        .clk(clk), .nrst(nrst), .start(start), .wdata(wdata), .wvalid(wvalid),
        .wready(wready), .config_data_in(config_data_in), .config_en(config_en),
        .config_data_out(config_data_out), .rdata(rdata), .rvalid(rvalid),
        .rready(rready), .busy(busy), .done(done)
    );

    // Physical chain: not touched by the loader's reset.
    logic [CL-1:0] chain = '0;
    assign config_data_out = chain[CL-1];
    always @(posedge clk) if (config_en) chain <= {chain[CL-2:0], config_data_in};

    int cyc = 0, en_cnt = 0, acc_cnt = 0, done_cnt = 0, rb_cnt = 0, done_cyc = 0;
    logic [WW-1:0] rb_log [0:63];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (config_en) en_cnt <= en_cnt + 1;
        if (wvalid && wready) acc_cnt <= acc_cnt + 1;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc + 1;
        end
        if (rvalid && rready && rb_cnt < 64) begin
            rb_log[rb_cnt] <= rdata;
            rb_cnt <= rb_cnt + 1;
        end
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        int n = 0;
        wvalid = 1'b1;
        wdata  = w;
        while (!wready && n < 100) begin
            tick();
            n++;
        end
        check_val("wready_wait", 32'(wready), 1);
        tick();
    endtask

    task automatic wait_en(input int target);
        int n = 0;
        while (en_cnt < target && n < 200) begin
            tick();
            n++;
        end
        check_val("en_wait", 32'(en_cnt >= target), 1);
    endtask

    task automatic wait_done(input int done0);
        int n = 0;
        while (done_cnt == done0 && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic do_load(input string name, input logic [7:0] w0, w1, w2,
                           input int gap, input int bp, input bit ovr,
                           input logic [7:0] e0, e1, e2, input logic [CL-1:0] echain);
        int en0, acc0, done0, rb0, s_cyc;
        logic [7:0] ws [3];
        ws    = '{w0, w1, w2};
        en0   = en_cnt;
        acc0  = acc_cnt;
        done0 = done_cnt;
        rb0   = rb_cnt;
        rready = (bp > 0) ? 1'b0 : 1'b1;
        pulse_start();
        s_cyc = cyc;
        check_val({name, "_busy_wready"}, 32'({busy, wready}), 32'h3);
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    if (gap > 0 && i > 0) begin
                        wvalid = 1'b0;
                        wait_en(en0 + 8 * i);
                        for (int g = 0; g < gap; g++) begin
                            check_val({name, "_gap_en"}, 32'(config_en), 0);
                            tick();
                        end
                    end
                    send_word(ws[i]);
                end
                if (ovr) begin
                    wdata  = 8'hAA;
                    wvalid = 1'b1;
                    start  = 1'b1;
                    tick();
                    start  = 1'b0;
                    wait_done(done0);
                end
                wvalid = 1'b0;
            end
            begin
                if (bp > 0) begin
                    int n = 0;
                    while (!rvalid && n < 200) begin
                        tick();
                        n++;
                    end
                    for (int c = 0; c < bp; c++) begin
                        check_val({name, "_bp_rdata"}, 32'({rvalid, rdata}), 32'({1'b1, e0}));
                        tick();
                    end
                    check_val({name, "_bp_stall_bcnt"}, 32'(en_cnt - en0), 16);
                    check_val({name, "_bp_stall_en"}, 32'(config_en), 0);
                    rready = 1'b1;
                end
            end
        join
        wait_done(done0);
        tick();
        tick();
        check_val({name, "_en_cycles"}, 32'(en_cnt - en0), CL);
        check_val({name, "_done_pulses"}, 32'(done_cnt - done0), 1);
        check_val({name, "_accepted"}, 32'(acc_cnt - acc0), 3);
        check_val({name, "_rb_count"}, 32'(rb_cnt - rb0), 3);
        check_val({name, "_rb0"}, 32'(rb_log[rb0]), 32'(e0));
        check_val({name, "_rb1"}, 32'(rb_log[rb0 + 1]), 32'(e1));
        check_val({name, "_rb2"}, 32'(rb_log[rb0 + 2]), 32'(e2));
        check_val({name, "_chain"}, 32'(chain), 32'(echain));
        check_val({name, "_idle"}, 32'({busy, config_en, wready}), 0);
        if (gap == 0 && bp == 0 && !ovr)
            check_val({name, "_load_time"}, 32'(done_cyc - s_cyc), CL + 4);
        $display("load %s: readback %02h %02h %02h chain %05h shifts %0d",
                 name, rb_log[rb0], rb_log[rb0 + 1], rb_log[rb0 + 2], chain, en_cnt - en0);
    endtask

    initial begin
        int en0;
        nrst   = 1'b0;
        start  = 1'b0;
        wdata  = '0;
        wvalid = 1'b0;
        rready = 1'b1;
        repeat (3) tick();
        check_val("reset_outs", 32'({config_en, config_data_in, wready, rvalid, busy, done, rdata}), 0);
        nrst = 1'b1;
        tick();

        do_load("base",   8'h26, 8'h99, 8'h60, 0, 0, 1'b0, 8'h00, 8'h00, 8'h00, 20'h26996);
        do_load("reload", 8'h3F, 8'hFF, 8'hF0, 0, 0, 1'b0, 8'h26, 8'h99, 8'h60, 20'h3FFFF);
        do_load("starve", 8'h26, 8'h99, 8'h60, 5, 0, 1'b0, 8'h3F, 8'hFF, 8'hF0, 20'h26996);
        do_load("backpr", 8'h3F, 8'hFF, 8'hF0, 0, 10, 1'b0, 8'h26, 8'h99, 8'h60, 20'h3FFFF);
        do_load("overrun", 8'h26, 8'h99, 8'h60, 0, 0, 1'b1, 8'h3F, 8'hFF, 8'hF0, 20'h26996);

        // Abort a load of 0x3FFFF after 9 shifts into a chain holding 0x26996.
        rready = 1'b1;
        en0 = en_cnt;
        pulse_start();
        send_word(8'h3F);
        wdata = 8'hFF;
        wait_en(en0 + 9);
        nrst = 1'b0;
        #1;
        check_val("midrst_outs", 32'({config_en, config_data_in, wready, rvalid, busy, done, rdata}), 0);
        wvalid = 1'b0;
        tick();
        tick();
        check_val("midrst_chain", 32'(chain), 32'h32C7F);
        check_val("midrst_shifts", 32'(en_cnt - en0), 9);
        nrst = 1'b1;
        tick();
        do_load("post_rst", 8'h26, 8'h99, 8'h60, 0, 0, 1'b0, 8'h32, 8'hC7, 8'hF0, 20'h26996);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
